// File: rtl/eprisc_spi_master_v2.sv
// rtl/eprisc_spi_master_v2.sv - epRISC SPI master: 4 modes, 1..16-bit frames, TX/RX FIFOs, divided SCLK
module eprisc_spi_master_v2 #(
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [1:0]        iAddr,
  input  logic [15:0]       iData,
  output logic [15:0]       oData,
  input  logic              iWrite,
  input  logic              iEnable,
  output logic              oInt,
  input  logic              iMISO,
  output logic              oMOSI,
  output logic              oSCLK,
  output logic [NUM_SS-1:0] oSS
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;
  state_t r_state, w_next;

  logic [15:0]       r_ctrl;
  logic [DIV_W-1:0]  r_div, r_tmr;
  logic              r_rxovf, r_txovf;
  logic [15:0]       r_txm [FIFO_DEPTH];
  logic [15:0]       r_rxm [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]       r_tx_cnt, r_rx_cnt;
  logic              r_cpol, r_cpha, r_lsbf;
  logic [3:0]        r_len;
  logic [15:0]       r_tx_sh, r_rx_sh;
  logic [4:0]        r_edge;
  logic              r_mosi, r_sclk, r_int;
  logic [NUM_SS-1:0] r_ss;

  logic              w_wr, w_rd, w_en, w_busy, w_tick, w_edge, w_odd, w_last;
  logic              w_sample, w_change, w_load;
  logic              w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic              w_tx_push_req, w_tx_push, w_tx_pop, w_tx_ovf;
  logic              w_rx_push_req, w_rx_push, w_rx_pop, w_rx_ovf;
  logic [15:0]       w_head, w_aligned, w_aligned_sh, w_rx_next, w_rx_word, w_sh_next, w_rdata;
  logic              w_first, w_sh_head;
  logic [NUM_SS-1:0] w_ss_dec;

  assign w_wr       = iEnable && iWrite;
  assign w_rd       = iEnable && !iWrite;
  assign w_en       = r_ctrl[0];
  assign w_busy     = (r_state != S_IDLE);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == (AW+1)'(FIFO_DEPTH));

  assign w_tick   = (r_tmr == r_div);
  assign w_edge   = (r_state == S_SHIFT) && w_tick;
  assign w_odd    = ~r_edge[0];
  assign w_last   = (r_edge == {r_len, 1'b1});
  assign w_sample = w_edge && (r_cpha ? !w_odd : w_odd);
  assign w_change = w_edge && (r_cpha ? w_odd : (!w_odd && !w_last));

  // Frame load uses the live CTRL fields; they are latched into r_cpol..r_len at that edge.
  assign w_head       = r_txm[r_tx_rp];
  assign w_aligned    = r_ctrl[3] ? w_head : (w_head << (4'd15 - r_ctrl[7:4]));
  assign w_first      = r_ctrl[3] ? w_aligned[0] : w_aligned[15];
  assign w_aligned_sh = r_ctrl[3] ? {1'b0, w_aligned[15:1]} : {w_aligned[14:0], 1'b0};
  assign w_sh_head    = r_lsbf ? r_tx_sh[0] : r_tx_sh[15];
  assign w_sh_next    = r_lsbf ? {1'b0, r_tx_sh[15:1]} : {r_tx_sh[14:0], 1'b0};

  // LSB-first frames fill from the top, so they are right-justified when pushed.
  assign w_rx_next = !w_sample ? r_rx_sh :
                     (r_lsbf ? {iMISO, r_rx_sh[15:1]} : {r_rx_sh[14:0], iMISO});
  assign w_rx_word = r_lsbf ? (w_rx_next >> (4'd15 - r_len)) : w_rx_next;

  assign w_tx_push_req = w_wr && (iAddr == 2'd2);
  assign w_tx_pop      = w_load;
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf      = w_tx_push_req && w_tx_full && !w_tx_pop;
  assign w_rx_pop      = w_rd && (iAddr == 2'd2) && !w_rx_empty;
  assign w_rx_push_req = w_edge && w_last && w_en;
  assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf      = w_rx_push_req && w_rx_full && !w_rx_pop;

  always_comb begin
    for (int i = 0; i < NUM_SS; i++) begin
      w_ss_dec[i] = (r_ctrl[14:12] != 3'(i));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (iAddr)
      2'd0:    w_rdata = r_ctrl;
      2'd1:    w_rdata = {9'd0, r_txovf, r_rxovf, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_busy};
      2'd2:    w_rdata = w_rx_empty ? 16'd0 : r_rxm[r_rx_rp];
      default: w_rdata = 16'(r_div);
    endcase
  end

  assign oData = iEnable ? w_rdata : 16'bz;
  assign oInt  = r_int;
  assign oSCLK = (r_state == S_IDLE) ? r_ctrl[1] : r_sclk;
  assign oMOSI = ((r_state == S_IDLE) || (r_state == S_GAP)) ? 1'b1 : r_mosi;
  assign oSS   = r_ss | {NUM_SS{~w_en}};

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:  if (w_en && !w_tx_empty) begin w_load = 1'b1; w_next = S_LEAD; end
      S_LEAD:  if (w_tick) w_next = S_SHIFT;
      S_SHIFT: if (w_edge && w_last) w_next = S_TRAIL;
      S_TRAIL: if (w_tick) begin
                 if (r_ctrl[8] && w_en && !w_tx_empty) begin
                   w_load = 1'b1;
                   w_next = S_SHIFT;
                 end else begin
                   w_next = S_GAP;
                 end
               end
      S_GAP:   if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!w_en) begin
      w_next = S_IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_ctrl  <= '0;
      r_div   <= '0;
      r_rxovf <= 1'b0;
      r_txovf <= 1'b0;
    end else begin
      if (w_wr && iAddr == 2'd0) r_ctrl <= iData & 16'h77FF;
      if (w_wr && iAddr == 2'd3) r_div  <= DIV_W'(iData);
      if (w_wr && iAddr == 2'd1 && iData[5]) r_rxovf <= 1'b0;
      if (w_wr && iAddr == 2'd1 && iData[6]) r_txovf <= 1'b0;
      if (w_rx_ovf) r_rxovf <= 1'b1;
      if (w_tx_ovf) r_txovf <= 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (w_tx_push) r_txm[r_tx_wp] <= iData;
    if (w_rx_push) r_rxm[r_rx_wp] <= w_rx_word;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tmr    <= '0;
      r_edge   <= '0;
      r_tx_sh  <= '0;
      r_rx_sh  <= '0;
      r_mosi   <= 1'b1;
      r_sclk   <= 1'b0;
      r_int    <= 1'b0;
      r_ss     <= '1;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_lsbf   <= 1'b0;
      r_len    <= '0;
    end else begin
      r_int <= (r_ctrl[9] && !w_rx_empty) || (r_ctrl[10] && w_tx_empty);
      if (r_state != w_next || w_tick || r_state == S_IDLE) r_tmr <= '0;
      else                                                  r_tmr <= r_tmr + 1'b1;
      if (!w_en) begin
        r_ss   <= '1;
        r_mosi <= 1'b1;
      end else if (w_load) begin
        r_cpol  <= r_ctrl[1];
        r_cpha  <= r_ctrl[2];
        r_lsbf  <= r_ctrl[3];
        r_len   <= r_ctrl[7:4];
        r_ss    <= w_ss_dec;
        r_sclk  <= r_ctrl[1];
        r_edge  <= '0;
        r_rx_sh <= '0;
        // CPHA=0 puts the first bit on MOSI before the first SCLK edge.
        if (!r_ctrl[2]) begin
          r_mosi  <= w_first;
          r_tx_sh <= w_aligned_sh;
        end else begin
          r_tx_sh <= w_aligned;
        end
      end else begin
        if (w_edge) begin
          r_sclk  <= ~r_sclk;
          r_edge  <= r_edge + 5'd1;
          r_rx_sh <= w_rx_next;
          if (w_change) begin
            r_mosi  <= w_sh_head;
            r_tx_sh <= w_sh_next;
          end
        end
        if (r_state == S_TRAIL && w_tick) r_ss <= '1;
      end
    end
  end

endmodule

// File: tb/tb_eprisc_spi_master_v2.sv
// tb/tb_eprisc_spi_master_v2.sv - scoreboard bench for eprisc_spi_master_v2
module tb_eprisc_spi_master_v2;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [1:0]  iAddr = 2'd0;
  logic [15:0] iData = 16'd0;
  logic        iWrite = 1'b0;
  logic        iEnable = 1'b0;
  wire  [15:0] oData;
  wire         oInt, oMOSI, oSCLK, iMISO;
  wire  [3:0]  oSS;

  assign iMISO = oMOSI;

  eprisc_spi_master_v2 #(.NUM_SS(4), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iData(iData), .oData(oData),
    .iWrite(iWrite), .iEnable(iEnable), .oInt(oInt), .iMISO(iMISO), .oMOSI(oMOSI),
    .oSCLK(oSCLK), .oSS(oSS)
  );

  always #5 iClk = ~iClk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_rx[$];
  logic        exp_bits[$];
  logic        mon_en = 1'b0;
  logic        tb_cpol = 1'b0;
  logic        tb_cpha = 1'b0;
  logic        meas_en = 1'b0;
  int          ss_rises = 0;
  int          min_high = 1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: RX data on DATA reads, MOSI bits at the slave sampling edge, SS high runs.
  initial begin : monitor
    logic prev_sclk, prev_ss0, lead;
    int   high_run;
    prev_sclk = 1'b0;
    prev_ss0  = 1'b1;
    high_run  = 0;
    forever begin
      @(negedge iClk);
      if (iEnable && !iWrite && iAddr == 2'd2) begin
        if (exp_rx.size() == 0) chk("rx_unexpected_read", {16'd0, oData}, 32'hDEAD_0000);
        else                    chk("rx_data", {16'd0, oData}, {16'd0, exp_rx.pop_front()});
      end
      if (mon_en && oSS != 4'hF && oSCLK != prev_sclk) begin
        lead = (oSCLK != tb_cpol);
        if (lead != tb_cpha) begin
          if (exp_bits.size() == 0) chk("mosi_extra_bit", {31'd0, oMOSI}, 32'hDEAD_0001);
          else                      chk("mosi_bit", {31'd0, oMOSI}, {31'd0, exp_bits.pop_front()});
        end
      end
      if (oSS[0] && !prev_ss0) ss_rises++;
      if (oSS[0]) begin
        high_run++;
      end else begin
        if (meas_en && prev_ss0 && high_run < min_high) min_high = high_run;
        high_run = 0;
      end
      if (!meas_en) min_high = 1000;
      prev_sclk = oSCLK;
      prev_ss0  = oSS[0];
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(posedge iClk); #1;
    iEnable = 1'b1; iWrite = 1'b1; iAddr = a; iData = d;
    @(posedge iClk); #1;
    iEnable = 1'b0; iWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(posedge iClk); #1;
    iEnable = 1'b1; iWrite = 1'b0; iAddr = a;
    @(negedge iClk);
    d = oData;
    @(posedge iClk); #1;
    iEnable = 1'b0;
  endtask

  task automatic push_bits(input logic [15:0] d, input int len, input logic lsbf);
    for (int i = 0; i <= len; i++) exp_bits.push_back(lsbf ? d[i] : d[len-i]);
  endtask

  task automatic wait_idle();
    logic [15:0] s;
    int          t;
    t = 0;
    s = 16'h0001;
    while ((s[0] || !s[2]) && t < 500) begin
      bus_rd(2'd1, s);
      t++;
    end
    if (t >= 500) chk("wait_idle_timeout", {16'd0, s}, 32'h0000_0004);
  endtask

  task automatic wait_edges(input int n);
    logic ps;
    int   cnt, t;
    cnt = 0; t = 0; ps = oSCLK;
    while (cnt < n && t < 500) begin
      @(negedge iClk);
      if (oSCLK != ps) cnt++;
      ps = oSCLK;
      t++;
    end
    if (cnt < n) chk("sclk_edge_timeout", cnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] rd;
    logic        ps;
    int          t, c, pulses, first, second, r0;
    logic        cpol, cpha;

    repeat (3) @(posedge iClk);
    #3 iRst_n = 1'b1;
    @(negedge iClk);
    chk("rst_ss", oSS, 4'hF);
    chk("rst_sclk", oSCLK, 0);
    chk("rst_mosi", oMOSI, 1);
    chk("rst_int", oInt, 0);
    bus_rd(2'd1, rd); chk("rst_status", rd, 16'h0014);
    bus_rd(2'd0, rd); chk("rst_ctrl", rd, 16'h0000);
    bus_rd(2'd3, rd); chk("rst_div", rd, 16'h0000);

    // Mode 0, 8-bit 0xA5, DIV=1.
    mon_en = 1'b1;
    bus_wr(2'd3, 16'd1);
    bus_wr(2'd0, 16'h0071);
    push_bits(16'h00A5, 7, 1'b0);
    exp_rx.push_back(16'h00A5);
    bus_wr(2'd2, 16'h00A5);
    t = 0;
    while (oSS[0] && t < 50) begin @(negedge iClk); t++; end
    ps = oSCLK; t = 0; c = 0; pulses = 0; first = -1; second = -1;
    while (!oSS[0] && t < 400) begin
      @(negedge iClk);
      c++;
      if (oSCLK && !ps) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      ps = oSCLK;
      t++;
    end
    chk("m0_pulses", pulses, 8);
    chk("m0_period", second - first, 4);
    wait_idle();
    chk("m0_sclk_after", oSCLK, 0);
    bus_rd(2'd2, rd);

    // All four modes, 16-bit 0x8001.
    for (int m = 0; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      tb_cpol = cpol; tb_cpha = cpha;
      bus_wr(2'd0, 16'h00F1 | {13'd0, cpha, cpol, 1'b0});
      @(negedge iClk);
      chk("mode_sclk_before", oSCLK, cpol);
      push_bits(16'h8001, 15, 1'b0);
      exp_rx.push_back(16'h8001);
      bus_wr(2'd2, 16'h8001);
      wait_idle();
      chk("mode_sclk_after", oSCLK, cpol);
      bus_rd(2'd2, rd);
    end

    // LSB first, 4-bit 0x9.
    tb_cpol = 1'b0; tb_cpha = 1'b0;
    bus_wr(2'd0, 16'h0039);
    push_bits(16'h0009, 3, 1'b1);
    exp_rx.push_back(16'h0009);
    bus_wr(2'd2, 16'h0009);
    wait_idle();
    bus_rd(2'd2, rd);

    // HOLD=1: one SS window over three frames.
    bus_wr(2'd0, 16'h0170);
    bus_wr(2'd2, 16'h003C); bus_wr(2'd2, 16'h00C3); bus_wr(2'd2, 16'h005A);
    push_bits(16'h003C, 7, 1'b0); push_bits(16'h00C3, 7, 1'b0); push_bits(16'h005A, 7, 1'b0);
    exp_rx.push_back(16'h003C); exp_rx.push_back(16'h00C3); exp_rx.push_back(16'h005A);
    r0 = ss_rises;
    bus_wr(2'd0, 16'h0171);
    wait_idle();
    chk("hold_ss_rises", ss_rises - r0, 1);
    repeat (3) bus_rd(2'd2, rd);

    // HOLD=0: SS released for at least T+1 cycles between frames.
    bus_wr(2'd0, 16'h0070);
    bus_wr(2'd2, 16'h0011); bus_wr(2'd2, 16'h0022); bus_wr(2'd2, 16'h0033);
    push_bits(16'h0011, 7, 1'b0); push_bits(16'h0022, 7, 1'b0); push_bits(16'h0033, 7, 1'b0);
    exp_rx.push_back(16'h0011); exp_rx.push_back(16'h0022); exp_rx.push_back(16'h0033);
    r0 = ss_rises;
    meas_en = 1'b1;
    bus_wr(2'd0, 16'h0071);
    wait_idle();
    meas_en = 1'b0;
    chk("nohold_ss_rises", ss_rises - r0, 3);
    chk("nohold_gap_ge_3", (min_high >= 3) ? 1 : 0, 1);
    repeat (3) bus_rd(2'd2, rd);

    // Overflow flags, DIV=0, 4-bit frames.
    bus_wr(2'd3, 16'd0);
    bus_wr(2'd0, 16'h0030);
    for (int i = 0; i < 9; i++) bus_wr(2'd2, 16'(i));
    for (int i = 0; i < 8; i++) begin
      push_bits(16'(i), 3, 1'b0);
      exp_rx.push_back(16'(i));
    end
    bus_rd(2'd1, rd); chk("ovf_tx_status", rd, 16'h0052);
    bus_wr(2'd0, 16'h0031);
    wait_idle();
    bus_rd(2'd1, rd); chk("ovf_rx_full_status", rd, 16'h004C);
    push_bits(16'h0009, 3, 1'b0);
    bus_wr(2'd2, 16'h0009);
    wait_idle();
    bus_rd(2'd1, rd); chk("ovf_rx_status", rd, 16'h006C);
    bus_wr(2'd1, 16'h0060);
    bus_rd(2'd1, rd); chk("ovf_cleared_status", rd, 16'h000C);
    bus_wr(2'd0, 16'h0231);
    repeat (2) @(negedge iClk);
    chk("int_rx_set", oInt, 1);
    repeat (8) bus_rd(2'd2, rd);
    exp_rx.push_back(16'h0000);
    bus_rd(2'd2, rd);
    bus_rd(2'd1, rd); chk("drained_status", rd, 16'h0014);
    repeat (2) @(negedge iClk);
    chk("int_rx_clear", oInt, 0);
    bus_wr(2'd0, 16'h0431);
    repeat (2) @(negedge iClk);
    chk("int_tx_empty", oInt, 1);

    // EN cleared mid-frame; second TX word must survive.
    mon_en = 1'b0;
    bus_wr(2'd3, 16'd3);
    bus_wr(2'd0, 16'h00F0);
    bus_wr(2'd2, 16'h1234);
    bus_wr(2'd2, 16'h5678);
    bus_wr(2'd0, 16'h00F1);
    wait_edges(3);
    bus_wr(2'd0, 16'h00F0);
    chk("enclr_ss", oSS, 4'hF);
    @(posedge iClk); #1;
    chk("enclr_sclk", oSCLK, 0);
    chk("enclr_mosi", oMOSI, 1);
    repeat (80) @(posedge iClk);
    bus_rd(2'd1, rd); chk("enclr_status", rd, 16'h0010);

    // Async reset mid-frame.
    bus_wr(2'd0, 16'h00F1);
    wait_edges(3);
    chk("pre_rst_ss_active", oSS, 4'hE);
    #2 iRst_n = 1'b0;
    #1;
    chk("arst_ss", oSS, 4'hF);
    chk("arst_sclk", oSCLK, 0);
    chk("arst_mosi", oMOSI, 1);
    chk("arst_int", oInt, 0);
    #10 iRst_n = 1'b1;
    bus_rd(2'd1, rd); chk("arst_status", rd, 16'h0014);
    bus_rd(2'd0, rd); chk("arst_ctrl", rd, 16'h0000);
    bus_rd(2'd3, rd); chk("arst_div", rd, 16'h0000);

    chk("exp_rx_left", exp_rx.size(), 0);
    chk("exp_bits_left", exp_bits.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
